// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin scheduler sharing one sequential signed multiplier
// datapath among NUM_REQ requesters. The FSM runs IDLE -> LOAD -> RUN -> DONE.
// Every output is a register or a direct copy of one, so no combinational path
// exists from req to any output.
//
// Optional feature: define MULT_ARB_TIMEOUT_EN to abort an operation when RUN
// lasts TIMEOUT cycles without mul_zero. The aborted operation still returns an
// ack, with result=0 and err=1. When the macro is undefined, err is tied 0 and
// RUN waits indefinitely.
//
// Handshake: a requester raises req[i] with stable-or-not operands. The operands
// are captured on the grant edge. The requester keeps req[i] high until it sees
// its one-cycle ack[i], and drops req[i] in the cycle after ack. result is valid
// while any ack bit is high and holds until the next completion or reset.
module mult_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] op_a,
    input  logic [NUM_REQ*WIDTH-1:0] op_b,
    output logic [NUM_REQ-1:0]       ack,
    output logic [2*WIDTH-1:0]       result,
    output logic                     busy,
    output logic [WIDTH-1:0]         mul_a,
    output logic [WIDTH-1:0]         mul_b,
    output logic                     mul_load,
    output logic                     mul_reg_en,
    output logic                     mul_shift_en,
    input  logic                     mul_zero,
    input  logic [2*WIDTH-1:0]       mul_product,
    output logic                     err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8 || WIDTH < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("mult_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [NUM_REQ-1:0] idx_onehot;

`ifdef MULT_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] run_cnt;
    logic             err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Operands go to the datapath straight from the latched copies, so they stay
    // stable from LOAD through DONE regardless of what the requester does.
    assign mul_a = a_q;
    assign mul_b = b_q;

    // Round-robin pick: the lowest set req at or above ptr, else the lowest set req (wrap).
    always_comb begin
        grant_vld = |req;
        grant_idx = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                grant_idx = IDX_W'(j);
            end
        end
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req[j] && (IDX_W'(j) >= ptr)) begin
                grant_idx = IDX_W'(j);
            end
        end
    end

    // Operand mux for the requester about to be granted, plus the one-hot ack pattern.
    always_comb begin
        sel_a      = '0;
        sel_b      = '0;
        idx_onehot = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_idx == IDX_W'(j)) begin
                sel_a = op_a[j*WIDTH +: WIDTH];
                sel_b = op_b[j*WIDTH +: WIDTH];
            end
            if (idx == IDX_W'(j)) begin
                idx_onehot[j] = 1'b1;
            end
        end
    end

    // Scheduler FSM with registered Moore outputs; reset overrides everything, including mid-RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            ptr          <= '0;
            idx          <= '0;
            a_q          <= '0;
            b_q          <= '0;
            ack          <= '0;
            result       <= '0;
            busy         <= 1'b0;
            mul_load     <= 1'b0;
            mul_reg_en   <= 1'b0;
            mul_shift_en <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
            run_cnt      <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        state      <= LOAD;
                        idx        <= grant_idx;
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        busy       <= 1'b1;
                        mul_load   <= 1'b1;
                        mul_reg_en <= 1'b1;
                    end
                end
                LOAD: begin
                    state        <= RUN;
                    mul_load     <= 1'b0;
                    mul_shift_en <= 1'b1;
`ifdef MULT_ARB_TIMEOUT_EN
                    run_cnt      <= '0;
`endif
                end
                RUN: begin
                    // mul_zero has priority, so a flag arriving on the limit cycle is a normal completion.
                    if (mul_zero) begin
                        state        <= DONE;
                        result       <= mul_product;
                        ack          <= idx_onehot;
                        mul_shift_en <= 1'b0;
                        mul_reg_en   <= 1'b0;
`ifdef MULT_ARB_TIMEOUT_EN
                    end else if (run_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state        <= DONE;
                        result       <= '0;
                        ack          <= idx_onehot;
                        err_q        <= 1'b1;
                        mul_shift_en <= 1'b0;
                        mul_reg_en   <= 1'b0;
                    end else begin
                        run_cnt      <= run_cnt + CNT_W'(1);
`endif
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ack   <= '0;
                    busy  <= 1'b0;
                    ptr   <= (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + IDX_W'(1);
`ifdef MULT_ARB_TIMEOUT_EN
                    err_q <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: bench for mult_arbiter. The bench plays the requesters and
// the multiplier datapath. It predicts every output from a transaction-level
// timeline per operation (grant edge, number of RUN cycles, abort or not).
`timescale 1ns/1ps
module tb_mult_arbiter;

    localparam int N  = 2;
    localparam int W  = 8;
    localparam int PW = 2 * W;
    localparam int TO = 8;
`ifdef MULT_ARB_TIMEOUT_EN
    localparam int N_MAX = 10;
`else
    localparam int N_MAX = 6;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req = '0;
    logic [N*W-1:0] op_a = '0;
    logic [N*W-1:0] op_b = '0;
    logic [N-1:0]  ack;
    logic [PW-1:0] result;
    logic          busy;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_load;
    logic          mul_reg_en;
    logic          mul_shift_en;
    logic          mul_zero = 1'b0;
    logic [PW-1:0] mul_product = '0;
    logic          err;

    mult_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .ack(ack), .result(result), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_load(mul_load),
        .mul_reg_en(mul_reg_en), .mul_shift_en(mul_shift_en),
        .mul_zero(mul_zero), .mul_product(mul_product), .err(err)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Counters
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Requester intent
    logic [N-1:0] want = '0;
    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    bit           rand_mode = 1'b0;
    int           n_force = 0;

    // Reference model state
    bit            act = 1'b0;
    int            m_g, m_n, m_nreq, m_idx;
    bit            m_abort;
    logic [W-1:0]  m_a, m_b;
    int            ptr_m = 0;
    int            free_c = 0;
    logic [PW-1:0] exp_res = '0;
    logic [W-1:0]  exp_ma = '0;
    logic [W-1:0]  exp_mb = '0;

    // Completion scoreboard logs
    int            done_idx [$];
    int            done_cyc [$];
    int            load_cyc [$];
    logic [PW-1:0] done_res [$];
    logic          done_err [$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [PW-1:0] mul_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [PW-1:0] sa;
        logic signed [PW-1:0] sb;
        sa = {{W{a[W-1]}}, a};
        sb = {{W{b[W-1]}}, b};
        return sa * sb;
    endfunction

    task automatic drive_inputs();
        int e;
        e = cyc + 1;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!want[i] && $urandom_range(0, 3) == 0) begin
                    want[i] = 1'b1;
                    opa[i]  = W'($urandom);
                    opb[i]  = W'($urandom);
                end else if ($urandom_range(0, 7) == 0) begin
                    opa[i] = W'($urandom);
                    opb[i] = W'($urandom);
                end
            end
        end
        req = want;
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = opa[i];
            op_b[i*W +: W] = opb[i];
        end
        if (act && e >= m_g + 2 && e <= m_g + 1 + m_n) begin
            mul_zero    = !m_abort && (e == m_g + 1 + m_n);
            mul_product = mul_zero ? mul_ref(m_a, m_b) : PW'($urandom);
        end else begin
            mul_zero    = 1'($urandom_range(0, 1));
            mul_product = PW'($urandom);
        end
    endtask

    task automatic step();
        logic [N-1:0] e_ack;
        logic e_busy, e_load, e_shift, e_regen, e_err;
        bit found;
        int cand;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            act     = 1'b0;
            ptr_m   = 0;
            exp_res = '0;
            exp_ma  = '0;
            exp_mb  = '0;
            free_c  = cyc + 1;
        end else if (!act && cyc >= free_c && req != '0) begin
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                cand = (ptr_m + k) % N;
                if (!found && req[cand]) begin
                    found = 1'b1;
                    m_idx = cand;
                end
            end
            act    = 1'b1;
            m_g    = cyc;
            m_a    = op_a[m_idx*W +: W];
            m_b    = op_b[m_idx*W +: W];
            m_nreq = (n_force > 0) ? n_force : $urandom_range(1, N_MAX);
            n_force = 0;
`ifdef MULT_ARB_TIMEOUT_EN
            m_abort = (m_nreq > TO);
            m_n     = m_abort ? TO : m_nreq;
`else
            m_abort = 1'b0;
            m_n     = m_nreq;
`endif
            exp_ma = m_a;
            exp_mb = m_b;
            ptr_m  = (m_idx + 1) % N;
        end
        e_busy = 0; e_load = 0; e_shift = 0; e_regen = 0; e_err = 0; e_ack = '0;
        if (act) begin
            e_busy  = 1'b1;
            e_load  = (cyc == m_g);
            e_shift = (cyc > m_g) && (cyc <= m_g + m_n);
            e_regen = (cyc <= m_g + m_n);
            if (cyc == m_g + 1 + m_n) begin
                e_ack[m_idx] = 1'b1;
                e_err   = m_abort;
                exp_res = m_abort ? '0 : mul_ref(m_a, m_b);
            end
        end
        chk_eq("busy", busy, e_busy);
        chk_eq("mul_load", mul_load, e_load);
        chk_eq("mul_shift_en", mul_shift_en, e_shift);
        chk_eq("mul_reg_en", mul_reg_en, e_regen);
        chk_eq("ack", ack, e_ack);
        chk_eq("result", result, exp_res);
        chk_eq("err", err, e_err);
        chk_eq("mul_a", mul_a, exp_ma);
        chk_eq("mul_b", mul_b, exp_mb);
        if (act && cyc == m_g + 1 + m_n) begin
            act    = 1'b0;
            free_c = cyc + 2;
        end
        if (mul_load === 1'b1) load_cyc.push_back(cyc);
        for (int i = 0; i < N; i++) begin
            if (ack[i] === 1'b1) begin
                done_idx.push_back(i);
                done_cyc.push_back(cyc);
                done_res.push_back(result);
                done_err.push_back(err);
                want[i] = 1'b0;
            end
        end
        drive_inputs();
    endtask

    task automatic wait_done(input int target, input string tag);
        int budget;
        budget = 300;
        while (done_idx.size() < target && budget > 0) begin
            step();
            budget--;
        end
        if (done_idx.size() < target) chk_eq({tag, "_timeout"}, done_idx.size(), target);
    endtask

    task automatic wait_shift(input string tag);
        int budget;
        budget = 40;
        while (mul_shift_en !== 1'b1 && budget > 0) begin
            step();
            budget--;
        end
        if (mul_shift_en !== 1'b1) chk_eq({tag, "_shift_timeout"}, mul_shift_en, 1);
    endtask

    task automatic wait_load(input int target, input string tag);
        int budget;
        budget = 40;
        while (load_cyc.size() < target && budget > 0) begin
            step();
            budget--;
        end
        if (load_cyc.size() < target) chk_eq({tag, "_load_timeout"}, load_cyc.size(), target);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
    endtask

    initial begin
        int base;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end

        // Single request: -3 * 5
        do_reset(2);
        want[0] = 1'b1; opa[0] = 8'hFD; opb[0] = 8'h05;
        wait_done(1, "t1");
        chk_eq("t1_idx", done_idx[$], 0);
        chk_eq("t1_res", done_res[$], 16'hFFF1);
        step();
        chk_eq("t1_busy_after", busy, 0);

        // Both requesters held from reset: 7*-2 then -8*-8
        rst = 1'b1;
        want = 2'b11;
        opa[0] = 8'h07; opb[0] = 8'hFE;
        opa[1] = 8'hF8; opb[1] = 8'hF8;
        repeat (2) step();
        rst = 1'b0;
        base = done_idx.size();
        wait_done(base + 2, "t2");
        chk_eq("t2_first_idx", done_idx[base], 0);
        chk_eq("t2_first_res", done_res[base], 16'hFFF2);
        chk_eq("t2_second_idx", done_idx[base + 1], 1);
        chk_eq("t2_second_res", done_res[base + 1], 16'h0040);
        chk_eq("t2_idle_gap", load_cyc[$] - done_cyc[base], 2);

        // Pointer wrap, then requester 1 held through a requester-0 operation
        base = done_idx.size();
        want = 2'b11;
        wait_done(base + 2, "t3a");
        chk_eq("t3_wrap_idx0", done_idx[base], 0);
        chk_eq("t3_wrap_idx1", done_idx[base + 1], 1);
        want[0] = 1'b1;
        wait_load(load_cyc.size() + 1, "t3b");
        want[1] = 1'b1;
        base = done_idx.size();
        wait_done(base + 1, "t3b");
        chk_eq("t3_held_first", done_idx[base], 0);
        want[0] = 1'b1;
        wait_done(base + 2, "t3c");
        chk_eq("t3_held_next", done_idx[base + 1], 1);
        wait_done(base + 3, "t3d");

        // Operand change after grant: 4*4 with op_a0 changed during RUN
        base = done_idx.size();
        n_force = 4;
        want[0] = 1'b1; opa[0] = 8'h04; opb[0] = 8'h04;
        wait_shift("t4");
        opa[0] = 8'h01;
        wait_done(base + 1, "t4");
        chk_eq("t4_res", done_res[$], 16'h0010);

        // Reset mid-RUN, then 2*3
        n_force = 6;
        want[0] = 1'b1; opa[0] = 8'h09; opb[0] = 8'h09;
        wait_shift("t5");
        base = done_idx.size();
        rst = 1'b1;
        want[0] = 1'b0;
        step();
        rst = 1'b0;
        repeat (10) step();
        chk_eq("t5_no_ack", done_idx.size(), base);
        want[0] = 1'b1; opa[0] = 8'h02; opb[0] = 8'h03;
        wait_done(base + 1, "t5");
        chk_eq("t5_res", done_res[$], 16'h0006);

`ifdef MULT_ARB_TIMEOUT_EN
        // Timeout abort, then a completion exactly at the limit
        base = done_idx.size();
        n_force = 100;
        want[0] = 1'b1; opa[0] = 8'h05; opb[0] = 8'h05;
        wait_done(base + 1, "t6a");
        chk_eq("t6_abort_err", done_err[$], 1);
        chk_eq("t6_abort_res", done_res[$], 16'h0000);
        n_force = TO;
        want[1] = 1'b1; opa[1] = 8'h03; opb[1] = 8'hFF;
        wait_done(base + 2, "t6b");
        chk_eq("t6_limit_err", done_err[$], 0);
        chk_eq("t6_limit_res", done_res[$], 16'hFFFD);
`endif

        // Random traffic
        rand_mode = 1'b1;
        repeat (1500) step();
        rand_mode = 1'b0;
        for (int k = 0; k < 400 && want != '0; k++) step();
        chk_eq("drain", want, 0);
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
